// File: rtl/vp_mac_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module  : vp_mac_pkg
// Purpose : Shared state encoding, precision limit and beat packing widths
//           for the vp_temporal_mac upstream feeder.
// Revision: 1.0 - initial release
// ============================================================================
package vp_mac_pkg;

  localparam int PREC_MAX    = 8;
  localparam int ACT_DW_DEF  = 8;
  localparam int WGT_DW_DEF  = 8;
  localparam int AXIS_DW_DEF = 32;

  // Zero pad above {act, wgt} in a joined data beat
  localparam int PACK_PAD_W  = AXIS_DW_DEF - ACT_DW_DEF - WGT_DW_DEF;

  typedef logic [2:0] state_t;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_PREC  = 3'd1;
  localparam logic [2:0] ST_SCALE = 3'd2;
  localparam logic [2:0] ST_DATA  = 3'd3;
  localparam logic [2:0] ST_DRAIN = 3'd4;

  function automatic logic [3:0] clamp_prec(input logic [3:0] prec);
    return (prec > 4'(PREC_MAX)) ? 4'(PREC_MAX) : prec;
  endfunction

endpackage
`default_nettype wire

// File: rtl/vp_axis_join.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module  : vp_axis_join
// Purpose : Two-stream valid/ready join feeding a single-entry output
//           register that also accepts sequencer-supplied config beats.
// Revision: 1.0 - initial release
// ============================================================================
module vp_axis_join
  import vp_mac_pkg::*;
#(
  parameter int AXIS_DW = AXIS_DW_DEF,
  parameter int A_DW    = ACT_DW_DEF,
  parameter int B_DW    = WGT_DW_DEF,
  parameter int PAD_W   = PACK_PAD_W
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               i_sel_data,
  input  logic               i_cfg_load,
  input  logic [AXIS_DW-1:0] i_cfg_data,
  input  logic               i_cfg_user,
  input  logic [7:0]         i_data_id,
  input  logic               i_data_last,
  input  logic [A_DW-1:0]    i_a_data,
  input  logic               i_a_valid,
  output logic               o_a_ready,
  input  logic [B_DW-1:0]    i_b_data,
  input  logic               i_b_valid,
  output logic               o_b_ready,
  output logic [AXIS_DW-1:0] o_m_data,
  output logic               o_m_user,
  output logic               o_m_last,
  output logic [7:0]         o_m_id,
  output logic               o_m_valid,
  input  logic               i_m_ready,
  output logic               o_cfg_fire,
  output logic               o_data_fire,
  output logic               o_m_fire
);

  logic               r_valid;
  logic [AXIS_DW-1:0] r_data;
  logic               r_user;
  logic               r_last;
  logic [7:0]         r_id;

  logic               w_free;
  logic               w_cfg_fire;
  logic               w_data_fire;
  logic [AXIS_DW-1:0] w_joined;

  // Register can take a new beat when empty or emptying on this edge
  assign w_free      = ~r_valid | i_m_ready;
  assign w_cfg_fire  = i_cfg_load & w_free;
  assign w_data_fire = i_sel_data & i_a_valid & i_b_valid & w_free;
  assign w_joined    = {{PAD_W{1'b0}}, i_a_data, i_b_data};

  // Each side is ready only when its partner is valid, so neither is taken alone
  assign o_a_ready   = i_sel_data & i_b_valid & w_free;
  assign o_b_ready   = i_sel_data & i_a_valid & w_free;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_user  <= 1'b0;
      r_last  <= 1'b0;
      r_id    <= '0;
    end else if (w_cfg_fire) begin
      r_valid <= 1'b1;
      r_data  <= i_cfg_data;
      r_user  <= i_cfg_user;
      r_last  <= 1'b0;
      r_id    <= '0;
    end else if (w_data_fire) begin
      r_valid <= 1'b1;
      r_data  <= w_joined;
      r_user  <= 1'b0;
      r_last  <= i_data_last;
      r_id    <= i_data_id;
    end else if (i_m_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign o_m_data    = r_data;
  assign o_m_user    = r_user;
  assign o_m_last    = r_last;
  assign o_m_id      = r_id;
  assign o_m_valid   = r_valid;
  assign o_cfg_fire  = w_cfg_fire;
  assign o_data_fire = w_data_fire;
  assign o_m_fire    = r_valid & i_m_ready;

endmodule
`default_nettype wire

// File: rtl/vp_mac_feeder.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module  : vp_mac_feeder
// Purpose : Sequences precision, scale and joined act/wgt beats for the
//           vp_temporal_mac slave port, one job per accepted start.
// Revision: 1.0 - initial release
// ============================================================================
module vp_mac_feeder
  import vp_mac_pkg::*;
#(
  parameter int AXIS_DW       = 32,
  parameter int ACTIVATION_DW = 8,
  parameter int WEIGHT_DW     = 8,
  parameter int LEN_W         = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic [3:0]               cfg_precision,
  input  logic [AXIS_DW-1:0]       cfg_scale,
  input  logic [LEN_W-1:0]         cfg_len,
  output logic                     busy,
  output logic                     done,
  input  logic [ACTIVATION_DW-1:0] sa_axis_tdata,
  input  logic                     sa_axis_tvalid,
  output logic                     sa_axis_tready,
  input  logic [WEIGHT_DW-1:0]     sw_axis_tdata,
  input  logic                     sw_axis_tvalid,
  output logic                     sw_axis_tready,
  output logic [AXIS_DW-1:0]       mo_axis_tdata,
  output logic                     mo_axis_tuser,
  output logic                     mo_axis_tlast,
  output logic [7:0]               mo_axis_tid,
  output logic                     mo_axis_tvalid,
  input  logic                     mo_axis_tready
);

  state_t               r_state;
  logic [3:0]           r_prec;
  logic [AXIS_DW-1:0]   r_scale;
  logic [LEN_W-1:0]     r_len_m1;
  logic [LEN_W-1:0]     r_cnt;
  logic                 r_busy;
  logic                 r_done;

  logic                 w_cfg_load;
  logic                 w_cfg_user;
  logic [AXIS_DW-1:0]   w_cfg_data;
  logic                 w_sel_data;
  logic                 w_last;
  logic                 w_cfg_fire;
  logic                 w_data_fire;
  logic                 w_m_fire;

  assign w_cfg_load = (r_state == ST_PREC) | (r_state == ST_SCALE);
  assign w_cfg_user = (r_state == ST_PREC);
  assign w_cfg_data = (r_state == ST_PREC) ? {{(AXIS_DW-4){1'b0}}, r_prec} : r_scale;
  assign w_sel_data = (r_state == ST_DATA);
  assign w_last     = (r_cnt == r_len_m1);

  vp_axis_join #(
    .AXIS_DW (AXIS_DW),
    .A_DW    (ACTIVATION_DW),
    .B_DW    (WEIGHT_DW),
    .PAD_W   (AXIS_DW - ACTIVATION_DW - WEIGHT_DW)
  ) u_join (
    .clk         (clk),
    .reset       (reset),
    .i_sel_data  (w_sel_data),
    .i_cfg_load  (w_cfg_load),
    .i_cfg_data  (w_cfg_data),
    .i_cfg_user  (w_cfg_user),
    .i_data_id   (r_cnt[7:0]),
    .i_data_last (w_last),
    .i_a_data    (sa_axis_tdata),
    .i_a_valid   (sa_axis_tvalid),
    .o_a_ready   (sa_axis_tready),
    .i_b_data    (sw_axis_tdata),
    .i_b_valid   (sw_axis_tvalid),
    .o_b_ready   (sw_axis_tready),
    .o_m_data    (mo_axis_tdata),
    .o_m_user    (mo_axis_tuser),
    .o_m_last    (mo_axis_tlast),
    .o_m_id      (mo_axis_tid),
    .o_m_valid   (mo_axis_tvalid),
    .i_m_ready   (mo_axis_tready),
    .o_cfg_fire  (w_cfg_fire),
    .o_data_fire (w_data_fire),
    .o_m_fire    (w_m_fire)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= ST_IDLE;
      r_prec   <= '0;
      r_scale  <= '0;
      r_len_m1 <= '0;
      r_cnt    <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start && (cfg_len != '0)) begin
            r_prec   <= clamp_prec(cfg_precision);
            r_scale  <= cfg_scale;
            r_len_m1 <= cfg_len - 1'b1;
            r_state  <= ST_PREC;
          end
        end
        ST_PREC: begin
          // Busy rises together with the precision beat becoming valid
          if (w_cfg_fire) begin
            r_busy  <= 1'b1;
            r_state <= ST_SCALE;
          end
        end
        ST_SCALE: begin
          if (w_cfg_fire) begin
            r_cnt   <= '0;
            r_state <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (w_data_fire) begin
            r_cnt <= r_cnt + 1'b1;
            if (w_last) begin
              r_state <= ST_DRAIN;
            end
          end
        end
        ST_DRAIN: begin
          if (w_m_fire) begin
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign busy = r_busy;
  assign done = r_done;

endmodule
`default_nettype wire

// File: tb/tb_vp_mac_feeder.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module  : tb_vp_mac_feeder
// Purpose : Directed self-checking bench for vp_mac_feeder.
// Revision: 1.0 - initial release
// ============================================================================
module tb_vp_mac_feeder;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [3:0]  cfg_precision;
  logic [31:0] cfg_scale;
  logic [15:0] cfg_len;
  logic        busy;
  logic        done;
  logic [7:0]  sa_tdata;
  logic        sa_tvalid;
  logic        sa_tready;
  logic [7:0]  sw_tdata;
  logic        sw_tvalid;
  logic        sw_tready;
  logic [31:0] mo_tdata;
  logic        mo_tuser;
  logic        mo_tlast;
  logic [7:0]  mo_tid;
  logic        mo_tvalid;
  logic        mo_tready;

  always #5 clk = ~clk;

  vp_mac_feeder dut (
    .clk            (clk),
    .reset          (reset),
    .start          (start),
    .cfg_precision  (cfg_precision),
    .cfg_scale      (cfg_scale),
    .cfg_len        (cfg_len),
    .busy           (busy),
    .done           (done),
    .sa_axis_tdata  (sa_tdata),
    .sa_axis_tvalid (sa_tvalid),
    .sa_axis_tready (sa_tready),
    .sw_axis_tdata  (sw_tdata),
    .sw_axis_tvalid (sw_tvalid),
    .sw_axis_tready (sw_tready),
    .mo_axis_tdata  (mo_tdata),
    .mo_axis_tuser  (mo_tuser),
    .mo_axis_tlast  (mo_tlast),
    .mo_axis_tid    (mo_tid),
    .mo_axis_tvalid (mo_tvalid),
    .mo_axis_tready (mo_tready)
  );

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  logic [7:0]  act_mem [0:511];
  logic [7:0]  wgt_mem [0:511];
  int          src_len, a_idx, w_idx;
  bit          skew, stall;
  int          cyc, c0, done_cnt, done_cyc;

  logic [31:0] cap_data [$];
  logic        cap_user [$];
  logic        cap_last [$];
  logic [7:0]  cap_id   [$];
  int          cap_cyc  [$];

  logic        hold_pend;
  logic [31:0] hold_data;
  logic [7:0]  hold_id;
  logic [1:0]  hold_tags;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive_src(input logic a_f, input logic w_f);
    if (!sa_tvalid || a_f)
      sa_tvalid = (a_idx < src_len) && (!skew || ($urandom_range(0, 2) != 0));
    if (!sw_tvalid || w_f)
      sw_tvalid = (w_idx < src_len) && (!skew || ($urandom_range(0, 2) != 0));
    sa_tdata = act_mem[a_idx];
    sw_tdata = wgt_mem[w_idx];
  endtask

  task automatic cycle();
    logic a_f, w_f, m_f;
    @(negedge clk);
    a_f = sa_tvalid & sa_tready;
    w_f = sw_tvalid & sw_tready;
    m_f = mo_tvalid & mo_tready;
    if (a_f | w_f) chk("pair_consume", a_f, w_f);
    if (hold_pend) begin
      chk("hold_valid", mo_tvalid, 1'b1);
      chk("hold_data", mo_tdata, hold_data);
      chk("hold_id", mo_tid, hold_id);
      chk("hold_tags", {mo_tuser, mo_tlast}, hold_tags);
    end
    hold_pend = mo_tvalid & ~mo_tready;
    hold_data = mo_tdata;
    hold_id   = mo_tid;
    hold_tags = {mo_tuser, mo_tlast};
    if (m_f) begin
      cap_data.push_back(mo_tdata);
      cap_user.push_back(mo_tuser);
      cap_last.push_back(mo_tlast);
      cap_id.push_back(mo_tid);
      cap_cyc.push_back(cyc);
    end
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    @(posedge clk);
    #1;
    cyc++;
    start = 1'b0;
    if (a_f) a_idx++;
    if (w_f) w_idx++;
    drive_src(a_f, w_f);
    mo_tready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
  endtask

  task automatic start_job(input logic [3:0] p, input logic [31:0] s, input logic [15:0] l);
    cfg_precision = p;
    cfg_scale     = s;
    cfg_len       = l;
    start         = 1'b1;
    src_len       = int'(l);
    a_idx         = 0;
    w_idx         = 0;
    cap_data.delete();
    cap_user.delete();
    cap_last.delete();
    cap_id.delete();
    cap_cyc.delete();
    done_cnt      = 0;
    hold_pend     = 1'b0;
    sa_tvalid     = 1'b0;
    sw_tvalid     = 1'b0;
    drive_src(1'b0, 1'b0);
    c0            = cyc;
  endtask

  task automatic wait_done(input int budget, input string tag);
    int n = 0;
    while (done_cnt == 0 && n < budget) begin
      cycle();
      n++;
    end
    chk({tag, "_done_seen"}, done_cnt, 1);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; cfg_precision = '0; cfg_scale = '0; cfg_len = '0;
    sa_tvalid = 1'b0; sw_tvalid = 1'b0; sa_tdata = '0; sw_tdata = '0; mo_tready = 1'b1;
    skew = 1'b0; stall = 1'b0; src_len = 0; a_idx = 0; w_idx = 0; cyc = 0; c0 = 0;
    done_cnt = 0; done_cyc = 0; hold_pend = 1'b0;
    for (int k = 0; k < 512; k++) begin act_mem[k] = '0; wgt_mem[k] = '0; end

    // Reset state
    repeat (3) cycle();
    chk("rst_tvalid", mo_tvalid, 1'b0);
    chk("rst_tdata", mo_tdata, 32'h0);
    chk("rst_tuser", mo_tuser, 1'b0);
    chk("rst_tlast", mo_tlast, 1'b0);
    chk("rst_tid", mo_tid, 8'h0);
    chk("rst_readies", {sa_tready, sw_tready}, 2'b00);
    chk("rst_busy_done", {busy, done}, 2'b00);
    reset = 1'b0;
    cycle();

    // Nominal job
    act_mem[0] = 8'h11; act_mem[1] = 8'h22; act_mem[2] = 8'h33; act_mem[3] = 8'h44;
    wgt_mem[0] = 8'hA1; wgt_mem[1] = 8'hA2; wgt_mem[2] = 8'hA3; wgt_mem[3] = 8'hA4;
    start_job(4'd3, 32'h0000_009C, 16'd4);
    cycle();
    chk("nom_no_early_valid", mo_tvalid, 1'b0);
    cycle();
    chk("nom_prec_valid", mo_tvalid, 1'b1);
    chk("nom_prec_busy", busy, 1'b1);
    chk("nom_prec_data", mo_tdata, 32'h3);
    chk("nom_prec_user", mo_tuser, 1'b1);
    wait_done(40, "nom");
    chk("nom_busy_drop", busy, 1'b0);
    chk("nom_count", cap_data.size(), 6);
    chk("nom_b1", {cap_data[1], cap_user[1], cap_last[1], cap_id[1]}, {32'h9C, 1'b0, 1'b0, 8'd0});
    chk("nom_b2", {cap_data[2], cap_user[2], cap_last[2], cap_id[2]}, {32'h0000_11A1, 1'b0, 1'b0, 8'd0});
    chk("nom_b3", {cap_data[3], cap_user[3], cap_last[3], cap_id[3]}, {32'h0000_22A2, 1'b0, 1'b0, 8'd1});
    chk("nom_b4", {cap_data[4], cap_user[4], cap_last[4], cap_id[4]}, {32'h0000_33A3, 1'b0, 1'b0, 8'd2});
    chk("nom_b5", {cap_data[5], cap_user[5], cap_last[5], cap_id[5]}, {32'h0000_44A4, 1'b0, 1'b1, 8'd3});
    chk("nom_first_cyc", cap_cyc[0] - c0, 2);
    chk("nom_last_cyc", cap_cyc[5] - c0, 7);
    chk("nom_done_cyc", done_cyc - c0, 8);
    repeat (3) cycle();
    chk("nom_done_pulse", done_cnt, 1);

    // Stalls with skewed sources
    for (int k = 0; k < 10; k++) begin act_mem[k] = 8'h50 + 8'(k); wgt_mem[k] = 8'hB0 + 8'(k); end
    skew = 1'b1; stall = 1'b1;
    start_job(4'd6, 32'hDEAD_BEEF, 16'd10);
    wait_done(400, "stall");
    skew = 1'b0; stall = 1'b0;
    cycle();
    chk("stall_count", cap_data.size(), 12);
    chk("stall_prec", {cap_data[0], cap_user[0]}, {32'h6, 1'b1});
    chk("stall_scale", {cap_data[1], cap_user[1]}, {32'hDEAD_BEEF, 1'b0});
    for (int k = 0; k < 10; k++) begin
      chk($sformatf("stall_beat%0d", k),
          {cap_data[2+k], cap_user[2+k], cap_last[2+k], cap_id[2+k]},
          {16'h0, 8'h50 + 8'(k), 8'hB0 + 8'(k), 1'b0, (k == 9), 8'(k)});
    end

    // Precision clamp
    act_mem[0] = 8'h7E; wgt_mem[0] = 8'h5A;
    start_job(4'd12, 32'h1234_5678, 16'd1);
    wait_done(40, "clamp");
    chk("clamp_count", cap_data.size(), 3);
    chk("clamp_prec", {cap_data[0], cap_user[0]}, {32'h8, 1'b1});
    chk("clamp_data", {cap_data[2], cap_last[2], cap_id[2]}, {32'h0000_7E5A, 1'b1, 8'd0});

    // Zero-length start is ignored
    start_job(4'd3, 32'h1, 16'd0);
    for (int k = 0; k < 6; k++) begin
      cycle();
      chk("len0_busy_valid", {busy, mo_tvalid}, 2'b00);
    end
    chk("len0_no_done", done_cnt, 0);

    // Start while busy is ignored
    for (int k = 0; k < 5; k++) begin act_mem[k] = 8'h70 + 8'(k); wgt_mem[k] = 8'hE0 + 8'(k); end
    start_job(4'd2, 32'h0000_0100, 16'd5);
    repeat (3) cycle();
    cfg_precision = 4'd7; cfg_scale = 32'hFFFF_0000; cfg_len = 16'd2; start = 1'b1;
    cycle();
    wait_done(40, "busy_start");
    chk("busy_start_count", cap_data.size(), 7);
    chk("busy_start_prec", cap_data[0], 32'h2);
    chk("busy_start_scale", cap_data[1], 32'h100);
    chk("busy_start_last", {cap_data[6], cap_last[6], cap_id[6]}, {32'h0000_74E4, 1'b1, 8'd4});

    // Back-to-back: start on the cycle after done
    for (int k = 0; k < 3; k++) begin act_mem[k] = 8'h60 + 8'(k); wgt_mem[k] = 8'hC0 + 8'(k); end
    start_job(4'd5, 32'h0001_0000, 16'd3);
    wait_done(40, "b2b");
    chk("b2b_count", cap_data.size(), 5);
    chk("b2b_first_data", {cap_data[2], cap_id[2], cap_last[2]}, {32'h0000_60C0, 8'd0, 1'b0});
    chk("b2b_last_data", {cap_data[4], cap_id[4], cap_last[4]}, {32'h0000_62C2, 8'd2, 1'b1});
    chk("b2b_first_cyc", cap_cyc[0] - c0, 2);
    repeat (4) cycle();
    chk("b2b_single_done", done_cnt, 1);
    chk("b2b_no_extra", cap_data.size(), 5);

    // Reset after two data beats
    for (int k = 0; k < 6; k++) begin act_mem[k] = 8'h10 + 8'(k); wgt_mem[k] = 8'h90 + 8'(k); end
    start_job(4'd1, 32'h0000_0055, 16'd6);
    for (int n = 0; n < 20 && cap_data.size() < 4; n++) cycle();
    chk("mid_rst_progress", cap_data.size(), 4);
    reset = 1'b1;
    cycle();
    chk("mid_rst_tvalid", mo_tvalid, 1'b0);
    chk("mid_rst_payload", {mo_tdata, mo_tuser, mo_tlast, mo_tid}, 42'h0);
    chk("mid_rst_ctrl", {sa_tready, sw_tready, busy, done}, 4'b0000);
    reset = 1'b0;
    repeat (4) cycle();
    chk("mid_rst_no_done", done_cnt, 0);
    chk("mid_rst_idle", {mo_tvalid, busy}, 2'b00);
    act_mem[0] = 8'h01; act_mem[1] = 8'h02; wgt_mem[0] = 8'h81; wgt_mem[1] = 8'h82;
    start_job(4'd8, 32'h0002_0000, 16'd2);
    wait_done(40, "post_rst");
    chk("post_rst_count", cap_data.size(), 4);
    chk("post_rst_prec", {cap_data[0], cap_user[0]}, {32'h8, 1'b1});
    chk("post_rst_scale", cap_data[1], 32'h0002_0000);
    chk("post_rst_b0", {cap_data[2], cap_id[2], cap_last[2]}, {32'h0000_0181, 8'd0, 1'b0});
    chk("post_rst_b1", {cap_data[3], cap_id[3], cap_last[3]}, {32'h0000_0282, 8'd1, 1'b1});

    // Long job: TID wraps
    for (int k = 0; k < 300; k++) begin act_mem[k] = 8'(k); wgt_mem[k] = ~8'(k); end
    start_job(4'd4, 32'h0000_8000, 16'd300);
    wait_done(400, "long");
    chk("long_count", cap_data.size(), 302);
    chk("long_tid255", cap_id[257], 8'd255);
    chk("long_tid_wrap", {cap_id[258], cap_data[258]}, {8'd0, 32'h0000_00FF});
    chk("long_last_beat", {cap_data[301], cap_id[301], cap_last[301]}, {32'h0000_2BD4, 8'd43, 1'b1});
    begin
      int n_last = 0;
      foreach (cap_last[k]) if (cap_last[k] === 1'b1) n_last++;
      chk("long_single_tlast", n_last, 1);
    end
    chk("long_no_bubbles", cap_cyc[301] - cap_cyc[0], 301);
    chk("long_done_cyc", done_cyc - cap_cyc[301], 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/vp_mac_feeder.md
# vp_mac_feeder

Upstream sequencer for `vp_temporal_mac`. Takes a start pulse plus configuration (precision level, Q16.16 dequant scale, job length) and two independent 8-bit AXI-Stream inputs (activations, weights). Emits the exact beat sequence the MAC's slave port consumes:
- one precision beat (TUSER=1);
- one scale beat;
- CFG_LEN joined `{16'h0000, act, wgt}` beats, with TLAST on the final one.

## Interface
- AXIS_DW, 32, output stream data width
- ACTIVATION_DW, 8, activation stream width
- WEIGHT_DW, 8, weight stream width
- LEN_W, 16, width of job-length counter
- CLK  in  1  clock; all logic rising-edge
- RESET  in  1  asynchronous, active-high reset
- START  in  1  one-cycle job start request; honoured only in IDLE
- CFG_PRECISION  in  4  precision level 0..8; sampled at START
- CFG_SCALE  in  32  Q16.16 dequant scale (1/S_w); sampled at START
- CFG_LEN  in  LEN_W  number of data beats; sampled at START
- BUSY  out  1  high from accepted START until DONE
- DONE  out  1  one-cycle pulse after final beat handshake
- SA_AXIS_TDATA  in  ACTIVATION_DW  activation data
- SA_AXIS_TVALID  in  1  activation valid
- SA_AXIS_TREADY  out  1  activation ready
- SW_AXIS_TDATA  in  WEIGHT_DW  weight data
- SW_AXIS_TVALID  in  1  weight valid
- SW_AXIS_TREADY  out  1  weight ready
- MO_AXIS_TDATA  out  AXIS_DW  beat to MAC
- MO_AXIS_TUSER  out  1  1 = precision beat
- MO_AXIS_TLAST  out  1  last data beat of job
- MO_AXIS_TID  out  8  data-beat index, low 8 bits; 0 on config beats
- MO_AXIS_TVALID  out  1  output valid
- MO_AXIS_TREADY  in  1  MAC ready

## Operation
- States: IDLE, PREC, SCALE, DATA, DRAIN.
- IDLE: START with CFG_LEN != 0 latches config and goes to PREC. START with CFG_LEN == 0 is ignored (no beats, no DONE). START outside IDLE is ignored.
- PREC: loads the output register with TDATA = zero-extended precision, TUSER=1, TID=0. Precision values 9..15 are clamped to 8. Moves to SCALE when the register loads.
- SCALE: loads TDATA=CFG_SCALE, TUSER=0, TID=0, then moves to DATA.
- DATA: joins the two input streams.
  - A beat is consumed only when both TVALIDs are high and the output register is free (empty, or being drained this cycle).
  - SA_TREADY = SW_TVALID & free; SW_TREADY = SA_TVALID & free. Both streams are always consumed together; neither is ever consumed alone.
  - TDATA = `{16'h0000, act, wgt}`, TUSER=0, TID = beat counter[7:0].
  - TLAST=1 when counter == latched LEN-1; after loading that beat, go to DRAIN.
- DRAIN: waits for the last beat's handshake, pulses DONE, returns to IDLE.
- Output register rule: once TVALID is high, TDATA, TUSER, TLAST and TID hold stable until TREADY.
- The beat counter wraps at 2^LEN_W. TID wraps at 256.

## Timing
- Reset values: MO_AXIS_TVALID=0, TDATA=0, TUSER=0, TLAST=0, TID=0, SA/SW TREADY=0, BUSY=0, DONE=0, state=IDLE.
- START at edge t: precision beat valid at t+1, BUSY high from t+1.
- With MO_TREADY held high and inputs always valid, one beat per cycle with no bubbles. The job occupies LEN+2 consecutive cycles; DONE pulses on the cycle after the final handshake, and BUSY drops on that same cycle.
- Input TREADY is combinational from the other stream's TVALID and the output-free condition. There is no combinational path from SA/SW TVALID to MO_TVALID.
- Reset mid-job: the in-flight beat is dropped, no DONE is issued, and partially joined inputs are not consumed.

## Structure
- Package `vp_mac_pkg` holds:
  - the state enum;
  - PREC_MAX = 8;
  - the data-beat packing pad width (AXIS_DW − ACTIVATION_DW − WEIGHT_DW).
- Sub-module `vp_axis_join`: the 2-input valid/ready join plus the single-entry output register. The FSM drives its load/select inputs.

## Test plan
- Nominal job: PRECISION=3, SCALE=0x9C, LEN=4, acts 0x11,0x22,0x33,0x44, wgts 0xA1..0xA4, TREADY high → beats 0x3(TUSER=1), 0x9C, 0x00001 1A1 ... 0x000044A4. TLAST on 4th data beat only; TIDs 0,0,0,1,2,3; DONE one cycle after last beat.
- Stalls: random MO_TREADY plus random SA/SW TVALID skew, LEN=10 → output payload unchanged and held stable while stalled; no data beat pairs mismatched activation/weight; exactly 10 data beats.
- Clamp and zero-length: PRECISION=12 → precision beat 0x8. START with LEN=0 → no MO_TVALID, BUSY stays 0.
- START while BUSY, and back-to-back jobs: the second START is ignored. A START on the cycle after DONE begins a new job; its TID restarts at 0.
- Reset mid-DATA after 2 data beats: all outputs return to reset values on the next cycle; a fresh job runs correctly.
- LEN=300: TID wraps from 255 to 0; TLAST appears only on beat 299 (TID=43).
